// File: rtl/mc_controller_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle control path: opcodes, FSM states,
// instruction classes and the select codes consumed by npc, alu, ext and the datapath.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_RCALC, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_NOP
  } instr_class_e;

  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] A3_RD  = 2'b00;
  localparam logic [1:0] A3_RT  = 2'b01;
  localparam logic [1:0] A3_R31 = 2'b10;

  localparam logic [2:0] WD_ALU = 3'b000;
  localparam logic [2:0] WD_DM  = 3'b001;
  localparam logic [2:0] WD_EXT = 3'b010;
  localparam logic [2:0] WD_PC4 = 3'b011;

  localparam logic [1:0] IN2_R2  = 2'b00;
  localparam logic [1:0] IN2_EXT = 2'b01;

  // Static per-instruction control, a pure function of op_code/funct.
  typedef struct packed {
    instr_class_e cls;
    logic [2:0]   npc_op;
    logic [2:0]   alu_op;
    logic [1:0]   ext_op;
    logic [1:0]   a3_sel;
    logic [2:0]   wd_sel;
    logic [1:0]   in2_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface mc_ctrl_if #(parameter int CNT_W = 32);

  logic [5:0]       op_code;
  logic [5:0]       funct;
  logic             alu_is0;
  logic             dm_ready;
  logic             pc_we;
  logic             ir_we;
  logic             grf_we;
  logic             dm_we;
  logic [2:0]       npc_op;
  logic [2:0]       alu_op;
  logic [1:0]       ext_op;
  logic [1:0]       mux_grf_a3;
  logic [2:0]       mux_grf_wd;
  logic [1:0]       mux_alu_in2;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  op_code, funct, alu_is0, dm_ready,
    output pc_we, ir_we, grf_we, dm_we, npc_op, alu_op, ext_op,
           mux_grf_a3, mux_grf_wd, mux_alu_in2, state, retired_cnt
  );

  modport slave (
    output op_code, funct, alu_is0, dm_ready,
    input  pc_we, ir_we, grf_we, dm_we, npc_op, alu_op, ext_op,
           mux_grf_a3, mux_grf_wd, mux_alu_in2, state, retired_cnt
  );

endinterface

// File: rtl/mc_controller_decode.sv
// Combinational instruction decoder: classifies op_code/funct and yields the static
// control fields, which stay stable for as long as IR holds the instruction.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
    ctrl = '{cls: C_NOP, npc_op: NPC_PC4, alu_op: ALU_ADD, ext_op: EXT_ZERO,
             a3_sel: A3_RD, wd_sel: WD_ALU, in2_sel: IN2_R2};
    unique case (op_code)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          ctrl.cls = C_RCALC;
        end else if (funct == FN_SUBU) begin
          ctrl.cls    = C_RCALC;
          ctrl.alu_op = ALU_SUB;
        end else if (funct == FN_JR) begin
          ctrl.cls    = C_JR;
          ctrl.npc_op = NPC_JR;
        end
      end
      OP_ORI: begin
        ctrl.cls     = C_ORI;
        ctrl.alu_op  = ALU_OR;
        ctrl.in2_sel = IN2_EXT;
        ctrl.a3_sel  = A3_RT;
      end
      OP_LUI: begin
        ctrl.cls    = C_LUI;
        ctrl.ext_op = EXT_LUI;
        ctrl.a3_sel = A3_RT;
        ctrl.wd_sel = WD_EXT;
      end
      OP_LW: begin
        ctrl.cls     = C_LW;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.in2_sel = IN2_EXT;
        ctrl.a3_sel  = A3_RT;
        ctrl.wd_sel  = WD_DM;
      end
      OP_SW: begin
        ctrl.cls     = C_SW;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.in2_sel = IN2_EXT;
      end
      OP_BEQ: begin
        ctrl.cls    = C_BEQ;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl.cls    = C_J;
        ctrl.npc_op = NPC_JUMP;
      end
      OP_JAL: begin
        ctrl.cls    = C_JAL;
        ctrl.npc_op = NPC_JUMP;
        ctrl.a3_sel = A3_R31;
        ctrl.wd_sel = WD_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle IF/DCD/EXE/MEM/WB sequencer: per-state write enables, DM ready wait,
// and a wrapping count of committed instructions.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  ctrl_t            ctrl;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_we, ir_we, grf_we, dm_we;

  mc_decode u_decode (
    .op_code (bus.op_code),
    .funct   (bus.funct),
    .ctrl    (ctrl)
  );

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    grf_we  = 1'b0;
    dm_we   = 1'b0;
    unique case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        unique case (ctrl.cls)
          C_J, C_JR, C_NOP: begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        unique case (ctrl.cls)
          C_BEQ: begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Only lw/sw reach MEM; dm_ready is the sole exit condition.
        if (bus.dm_ready) begin
          if (ctrl.cls == C_SW) begin
            dm_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        grf_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // Reset suppresses every side effect in the cycle it is seen.
    if (rst) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      grf_we = 1'b0;
      dm_we  = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(pc_we);
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.ir_we       = ir_we;
  assign bus.grf_we      = grf_we;
  assign bus.dm_we       = dm_we;
  assign bus.npc_op      = (ctrl.cls == C_BEQ) ? (bus.alu_is0 ? NPC_BRANCH : NPC_PC4) : ctrl.npc_op;
  assign bus.alu_op      = ctrl.alu_op;
  assign bus.ext_op      = ctrl.ext_op;
  assign bus.mux_grf_a3  = ctrl.a3_sel;
  assign bus.mux_grf_wd  = ctrl.wd_sel;
  assign bus.mux_alu_in2 = ctrl.in2_sel;
  assign bus.state       = state_q;
  assign bus.retired_cnt = cnt_q;

endmodule
